uart_receiver: RTL
==================

# uart_receiver

Serial-to-byte front end of the core's load path. Samples the asynchronous `UART_RX` line with one system clock, recovers 8N1 frames at a fixed clocks-per-bit rate, and presents received bytes on a valid/ready stream to the program/data loader inside `top_sub`. An optional small FIFO absorbs loader stalls during back-to-back transfers such as a contest binary upload.

## Interface
- `CLK_PER_BIT`, 271: system clocks per UART bit; must be ≥ 8.
- `FIFO_DEPTH_LOG`, 2: log2 of FIFO entries; used only with `UART_RX_FIFO_EN`.
- `CLK` in 1: system clock; all logic on rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `UART_RX` in 1: serial line; idle high; asynchronous to `CLK`.
- `rx_data` out 8: received byte.
- `rx_valid` out 1: `rx_data` holds a byte.
- `rx_ready` in 1: consumer accepts the byte.
- `frame_err` out 1: one-cycle pulse when the stop bit samples low.
- `overrun` out 1: sticky; set when a completed byte is dropped; cleared only by reset.

## Operation
- `UART_RX` passes through a 2-FF synchronizer, reset to 1. Falling-edge detect uses the synchronized value and its one-cycle delayed copy.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: on a synchronized falling edge, clear the baud counter and go to START.
- START: at count `CLK_PER_BIT/2` (integer division), sample. If the line is high, it was a glitch: return to IDLE. If low, clear the counter and go to DATA.
- DATA: every `CLK_PER_BIT` counts, sample one bit, LSB first, shifting into bit 7 of the shift register (shift right). After the 8th bit, go to STOP.
- STOP: after `CLK_PER_BIT` counts, sample.
  - High: push the byte.
  - Low: pulse `frame_err`, discard the byte.
  - Either way, go to IDLE. The next start bit needs a fresh falling edge, so a held-low line (break) produces exactly one `frame_err`.
- Baud counter: `$clog2(CLK_PER_BIT)` bits; it never wraps within a bit period.
- Stream handshake: a transfer occurs when `rx_valid && rx_ready`. `rx_data` is held stable while `rx_valid && !rx_ready`.
- Reset mid-frame: FSM returns to IDLE and storage empties. A frame in flight is lost with no `frame_err`.

## Timing
- Reset values:
  - outputs: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0
  - internal: FSM=IDLE, counter=0, synchronizer=1.
- Let edge detection occur at cycle T0 (2–3 cycles after the line falls). Samples then fall at:
  - start bit: T0+`CLK_PER_BIT/2`
  - data bit i (i = 0..7): T0+`CLK_PER_BIT/2`+(i+1)·`CLK_PER_BIT`
  - stop bit: T0+`CLK_PER_BIT/2`+9·`CLK_PER_BIT`
- Push occurs on the stop-sample cycle. `rx_valid` rises the next cycle; there is no combinational fall-through.
- Stop processing ends at mid-stop-bit, so back-to-back frames with zero idle gap are received. A sender tolerance of ±2% is met.
- `frame_err` is high for exactly the cycle after the stop sample.

## Configuration
- `UART_RX_FIFO_EN` defined:
  - Storage is a FIFO of 2**`FIFO_DEPTH_LOG` entries; `rx_data` comes from the head.
  - Push while full with no pop in the same cycle: the byte is dropped and `overrun` is set.
  - Push and pop in the same cycle while full: both succeed, occupancy unchanged.
  - Push and pop in the same cycle while empty: the pop is ignored and the byte is stored.
  - Pointers wrap modulo depth. Full and empty are distinguished by an extra pointer bit.
- Undefined:
  - Storage is a single holding register.
  - Push when `rx_valid && !rx_ready`: the new byte is dropped and `overrun` is set.
  - Push when `rx_valid && rx_ready`: the byte is accepted and `rx_valid` stays high.

## Structure
- Shared package `uart_pkg`:
  - `rx_state_t` enum (IDLE, START, DATA, STOP)
  - `UART_DATA_BITS` = 8
  - `DEFAULT_CLK_PER_BIT` = 271
- Sub-module `uart_rx_fifo`: parameterised synchronous FIFO with push/pop/full/empty and async active-low reset. It is instantiated only under `UART_RX_FIFO_EN`.

## Test plan
- `CLK_PER_BIT`=16. Send 0xA5 with `rx_ready`=1.
  - Expect `rx_data`=0xA5 and `rx_valid` high for one cycle.
  - `rx_valid` rises the cycle after the stop sample (T0+153).
- Send 0x00, 0xFF, 0x3C back-to-back with no idle gap.
  - Expect three bytes in order, no `frame_err`.
- Pull the line low for 4 cycles, then high.
  - Expect return to IDLE, no push, no `frame_err`.
- Send 0x55 with the stop bit forced low.
  - Expect a `frame_err` pulse and `rx_valid` staying 0.
  - Then hold the line low for 40 bit times: still only one `frame_err`.
- `rx_ready`=0, FIFO enabled, depth 4. Send 5 bytes 0x01–0x05.
  - Expect `overrun`=1.
  - Raising `rx_ready` drains 0x01–0x04; 0x05 is lost.
  - Without the macro, only 0x01 is kept and `overrun` sets on the 2nd byte.
- Assert `RST_N` low during data bit 3 of a frame.
  - Expect all outputs at their reset values.
  - The next full frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int UART_DATA_BITS      = 8;
    localparam int DEFAULT_CLK_PER_BIT = 271;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO buffering received bytes; pointers carry an extra wrap bit
// so that full and empty can be told apart.
module uart_rx_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH_LOG = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] PTR_ONE = 1;

    logic [DEPTH_LOG:0] wr_q, wr_d;
    logic [DEPTH_LOG:0] rd_q, rd_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               do_push;
    logic               do_pop;

    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[DEPTH_LOG] != rd_q[DEPTH_LOG]) &&
                      (wr_q[DEPTH_LOG-1:0] == rd_q[DEPTH_LOG-1:0]);
    assign pop_data = mem_q[rd_q[DEPTH_LOG-1:0]];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = do_push ? wr_q + PTR_ONE : wr_q;
        rd_d    = do_pop  ? rd_q + PTR_ONE : rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (do_push) begin
                mem_q[wr_q[DEPTH_LOG-1:0]] <= push_data;
            end
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with valid/ready byte output. Define UART_RX_FIFO_EN to buffer
// bytes in a FIFO; otherwise a single holding register is used.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT    = DEFAULT_CLK_PER_BIT,
    parameter int FIFO_DEPTH_LOG = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       UART_RX,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    if (CLK_PER_BIT < 8 || FIFO_DEPTH_LOG < 1) begin : g_bad_param
        $error("uart_receiver: CLK_PER_BIT must be >= 8 and FIFO_DEPTH_LOG >= 1");
    end

    logic       rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;
    logic       push;
    logic       fall;

    assign fall      = rx_prev_q && !rx_sync_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    // Each sample point resets the counter, so START ends mid-bit and later bits are
    // sampled a whole bit period apart, ending the frame at mid-stop-bit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[UART_DATA_BITS-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    state_d     = IDLE;
                    push        = rx_sync_q;
                    frame_err_d = !rx_sync_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= UART_RX;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;
    logic pop;

    assign pop       = rx_ready && !fifo_empty;
    assign rx_valid  = !fifo_empty;
    assign overrun_d = overrun_q || (push && fifo_full && !pop);

    uart_rx_fifo #(
        .WIDTH    (UART_DATA_BITS),
        .DEPTH_LOG(FIFO_DEPTH_LOG)
    ) u_fifo (
        .clk      (CLK),
        .rst_n    (RST_N),
        .push     (push),
        .push_data(shift_q),
        .pop      (pop),
        .pop_data (rx_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );
`else
    logic [UART_DATA_BITS-1:0] hold_data_q, hold_data_d;
    logic hold_valid_q, hold_valid_d;

    assign rx_data  = hold_data_q;
    assign rx_valid = hold_valid_q;

    // A byte arriving while the consumer stalls is dropped; the held byte stays put.
    always_comb begin
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        overrun_d    = overrun_q;
        if (push) begin
            if (hold_valid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end else begin
                hold_data_d  = shift_q;
                hold_valid_d = 1'b1;
            end
        end else if (hold_valid_q && rx_ready) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
        end
    end
`endif

endmodule
